rr_grant: RTL and testbench
===========================

RR_GRANT -- requirements
Module: rr_grant

Interface
REQ-001 Parameter HOLD_MAX, default 15, maximum cycles a grant is held before forced release; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  4  request lines, one per requester; level-sensitive.
REQ-005 done  input  1  owner of the current grant releases the grant; sampled only in GRANT.
REQ-006 gnt  output  4  one-hot grant, registered; all-zero when no grant is active.
REQ-007 gnt_id  output  2  binary index of the granted requester; holds its last value when gnt is zero.
REQ-008 busy  output  1  high exactly while gnt is non-zero.
REQ-009 any_req  output  1  registered OR of req[3:0], one cycle behind req.
REQ-010 timeout  output  1  one-cycle pulse marking a forced release.
REQ-011 grant_cnt  output  8  number of grants issued, wraps 255 -> 0.

Function
REQ-012 The block SHALL implement three states: IDLE, GRANT, RELEASE.
REQ-013 In IDLE or RELEASE with req non-zero, the block SHALL select the first set req bit in order ptr, ptr+1, ptr+2, ptr+3 (mod 4), enter GRANT on the next edge, and drive the matching gnt bit and gnt_id.
REQ-014 Grant latency SHALL be exactly one cycle: req sampled high at edge N gives gnt high after edge N.
REQ-015 In IDLE or RELEASE with req all-zero, the block SHALL go to or stay in IDLE with gnt=0.
REQ-016 On entry to GRANT, the block SHALL clear an 8-bit hold timer and increment grant_cnt by 1.
REQ-017 In GRANT, the hold timer SHALL increment once per cycle.
REQ-018 The block SHALL leave GRANT for RELEASE when done=1, or req[gnt_id]=0, or the hold timer equals HOLD_MAX-1, whichever occurs first.
REQ-019 A grant SHALL last at most HOLD_MAX cycles.
REQ-020 In RELEASE, gnt SHALL be 0, busy SHALL be 0, and ptr SHALL equal gnt_id+1 mod 4, giving round-robin fairness.
REQ-021 RELEASE SHALL last exactly one cycle and arbitrate as in REQ-013.
REQ-022 There SHALL be at least one cycle with gnt=0 between two grants, including two consecutive grants to the same requester.
REQ-023 timeout SHALL be 1 only during the RELEASE cycle caused by the timer.
REQ-024 If done or withdrawal coincides with the timer limit, timeout SHALL still be 1 (timer has priority for the flag).
REQ-025 Changes to req while in GRANT, other than on the granted bit, SHALL NOT affect the current grant.
REQ-026 gnt SHALL never have more than one bit set.
REQ-027 done asserted outside GRANT SHALL be ignored.

Reset
REQ-028 While rst_n=0, the block SHALL immediately force state=IDLE, gnt=0, gnt_id=0, busy=0, any_req=0, timeout=0, grant_cnt=0, ptr=0, hold timer=0, independent of clk.
REQ-029 Reset asserted mid-grant SHALL drop gnt within the same cycle.
REQ-030 After rst_n rises, the first edge with req non-zero SHALL grant per REQ-013 with ptr=0.

Verification
REQ-031 Single request: reset, req=4'b0100 held, done=1 on the 3rd grant cycle -> gnt=4'b0100 one cycle after req, gnt_id=2, busy=1 for 3 cycles, then one RELEASE cycle with gnt=0; re-grant to 2; grant_cnt=2.
REQ-032 Round-robin: req=4'b1111 held, done pulsed each grant's 1st cycle -> grant order 0,1,2,3,0 with a one-cycle gap between grants.
REQ-033 Timeout: HOLD_MAX=4, req=4'b0001 held, done=0 -> gnt=1 for exactly 4 cycles, then timeout=1 for one cycle; timeout=1 also when done=1 on the 4th cycle.
REQ-034 Withdrawal: granted requester 3 drops req[3] while req[1]=1 -> RELEASE next cycle, timeout=0, then gnt=4'b0010.
REQ-035 Async reset: assert rst_n=0 between edges during GRANT -> gnt, busy, and grant_cnt go to 0 before the next edge; after release, req=4'b1000 -> gnt_id=3.
REQ-036 Counter wrap: 256 grants -> grant_cnt reads 0.

Source files
------------

// File: rtl/rr_grant.sv
// Four-way round-robin grant with hold limit, forced release and grant counter.
// One-hot registered grant; a one-cycle gap always separates two grants.
module rr_grant #(
  parameter int unsigned HOLD_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       busy,
  output logic       any_req,
  output logic       timeout,
  output logic [7:0] grant_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_REL   = 2'd2;

  localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX - 1);

  logic [1:0] state;
  logic [1:0] ptr;
  logic [7:0] hold;

  logic       pick_vld;
  logic [1:0] pick_id;
  logic [1:0] cand;
  logic       hold_hit;
  logic       own_req;
  logic       leave;

  // Scan from ptr downwards in priority so the nearest set bit wins last.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = ptr;
    cand     = ptr;
    for (int i = 3; i >= 0; i--) begin
      cand = ptr + 2'(i);
      if (req[cand]) begin
        pick_vld = 1'b1;
        pick_id  = cand;
      end
    end
  end

  assign hold_hit = (hold == HOLD_LIM);
  assign own_req  = req[gnt_id];
  assign leave    = done | ~own_req | hold_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      gnt       <= 4'b0;
      gnt_id    <= 2'd0;
      busy      <= 1'b0;
      any_req   <= 1'b0;
      timeout   <= 1'b0;
      grant_cnt <= 8'd0;
      ptr       <= 2'd0;
      hold      <= 8'd0;
    end else begin
      any_req <= |req;
      timeout <= 1'b0;
      case (state)
        S_GRANT: begin
          hold <= hold + 8'd1;
          if (leave) begin
            state   <= S_REL;
            gnt     <= 4'b0;
            busy    <= 1'b0;
            ptr     <= gnt_id + 2'd1;
            timeout <= hold_hit;
          end
        end
        S_IDLE, S_REL: begin
          if (pick_vld) begin
            state     <= S_GRANT;
            gnt       <= 4'b1 << pick_id;
            gnt_id    <= pick_id;
            busy      <= 1'b1;
            hold      <= 8'd0;
            grant_cnt <= grant_cnt + 8'd1;
          end else begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          gnt   <= 4'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_grant.sv
// Bench for rr_grant: grant-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_rr_grant;

  localparam int HMAX = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       any_req;
  logic       timeout;
  logic [7:0] grant_cnt;

  int n_vec;
  int n_err;

  rr_grant #(.HOLD_MAX(HMAX)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .done     (done),
    .gnt      (gnt),
    .gnt_id   (gnt_id),
    .busy     (busy),
    .any_req  (any_req),
    .timeout  (timeout),
    .grant_cnt(grant_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Grant-level model: owner is -1 when nobody holds the grant;
  // age counts grant cycles served so far, starting at 1.
  int m_owner;
  int m_age;
  int m_ptr;
  int m_cnt;
  int m_last;
  bit m_to;
  bit m_any;
  int m_pick;

  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  always_comb m_pick = rr_pick(req, m_ptr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner <= -1;
      m_age   <= 0;
      m_ptr   <= 0;
      m_cnt   <= 0;
      m_last  <= 0;
      m_to    <= 1'b0;
      m_any   <= 1'b0;
    end else begin
      m_any <= (req != 4'b0);
      m_to  <= 1'b0;
      if (m_owner >= 0) begin
        if (done || !req[m_owner] || m_age == HMAX) begin
          m_owner <= -1;
          m_ptr   <= (m_owner + 1) % 4;
          m_to    <= (m_age == HMAX);
        end else begin
          m_age <= m_age + 1;
        end
      end else if (req != 4'b0) begin
        m_owner <= m_pick;
        m_last  <= m_pick;
        m_age   <= 1;
        m_cnt   <= (m_cnt + 1) % 256;
      end
    end
  end

  always @(negedge clk) begin
    logic [3:0] e_gnt;
    e_gnt = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
    n_vec++;
    if (gnt !== e_gnt || gnt_id !== 2'(m_last) || busy !== (m_owner >= 0) ||
        any_req !== m_any || timeout !== m_to || grant_cnt !== 8'(m_cnt) ||
        $countones(gnt) > 1) begin
      n_err++;
      $display("FAIL model t=%0t got gnt=%b id=%0d busy=%b any=%b to=%b cnt=%0d want gnt=%b id=%0d busy=%b any=%b to=%b cnt=%0d",
               $time, gnt, gnt_id, busy, any_req, timeout, grant_cnt,
               e_gnt, m_last, (m_owner >= 0), m_any, m_to, m_cnt);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] r, input logic d);
    req  = r;
    done = d;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0;
    done  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    req   = 4'b0;
    done  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_id", int'(gnt_id), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cnt", int'(grant_cnt), 0);
    rst_n = 1'b1;

    // single requester, done in third grant cycle
    drive(4'b0100, 1'b0);
    chk("single_gnt", int'(gnt), 4);
    chk("single_id", int'(gnt_id), 2);
    drive(4'b0100, 1'b0);
    drive(4'b0100, 1'b0);
    chk("single_busy3", int'(busy), 1);
    drive(4'b0100, 1'b1);
    chk("single_rel", int'(gnt), 0);
    chk("single_rel_to", int'(timeout), 0);
    drive(4'b0100, 1'b0);
    chk("single_regnt", int'(gnt), 4);
    chk("single_cnt", int'(grant_cnt), 2);
    drive(4'b0000, 1'b0);
    drive(4'b0000, 1'b0);

    // round robin order from a fresh pointer
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(4'b1111, 1'b0);
      chk("rr_id", int'(gnt_id), k % 4);
      chk("rr_gnt", int'(gnt), 1 << (k % 4));
      drive(4'b1111, 1'b1);
      chk("rr_gap", int'(gnt), 0);
    end
    drive(4'b0000, 1'b0);

    // hold limit, alone and coinciding with done
    for (int k = 0; k < 4; k++) drive(4'b0001, 1'b0);
    chk("to_hold4", int'(gnt), 1);
    drive(4'b0001, 1'b0);
    chk("to_rel", int'(gnt), 0);
    chk("to_pulse", int'(timeout), 1);
    drive(4'b0001, 1'b0);
    chk("to_clear", int'(timeout), 0);
    chk("to_regnt", int'(gnt), 1);
    for (int k = 0; k < 3; k++) drive(4'b0001, 1'b0);
    drive(4'b0001, 1'b1);
    chk("to_done_pulse", int'(timeout), 1);
    drive(4'b0000, 1'b0);
    drive(4'b0000, 1'b0);

    // withdrawal by the owner
    drive(4'b1000, 1'b0);
    chk("wd_id", int'(gnt_id), 3);
    drive(4'b0010, 1'b0);
    chk("wd_rel", int'(gnt), 0);
    chk("wd_to", int'(timeout), 0);
    drive(4'b0010, 1'b0);
    chk("wd_next", int'(gnt), 2);
    drive(4'b0000, 1'b0);
    drive(4'b0000, 1'b0);

    // reset between edges while granted
    drive(4'b1000, 1'b0);
    chk("ar_pre", int'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_gnt", int'(gnt), 0);
    chk("ar_busy", int'(busy), 0);
    chk("ar_cnt", int'(grant_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b1000, 1'b0);
    chk("ar_id", int'(gnt_id), 3);
    chk("ar_cnt1", int'(grant_cnt), 1);
    drive(4'b0000, 1'b0);
    drive(4'b0000, 1'b0);

    // counter wrap; done while not granted must be ignored
    do_reset();
    for (int i = 1; i <= 511; i++) begin
      drive(4'b0001, 1'b1);
      if (i == 509) chk("wrap_255", int'(grant_cnt), 255);
      if (i == 511) begin
        chk("wrap_0", int'(grant_cnt), 0);
        chk("wrap_gnt", int'(gnt), 1);
      end
    end
    drive(4'b0000, 1'b0);
    drive(4'b0000, 1'b0);

    // mixed traffic against the model
    for (int i = 0; i < 300; i++) begin
      logic [3:0] r;
      logic       d;
      r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) r = 4'b0;
      d = ($urandom_range(0, 4) == 0);
      drive(r, d);
    end
    drive(4'b0000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
